// File: rtl/mult_accum_pkg.sv
// rtl/mult_accum_pkg.sv - shared types and helpers for the multiply-accumulate block
package mult_accum_pkg;

    // Width of the saturation constant helpers; callers size-cast down to their own width.
    localparam int SAT_MAX_W = 128;

    // Control payload travelling alongside each sample through the pipeline.
    typedef struct packed {
        logic valid;
        logic is_signed;
        logic addnsub;
        logic sload;
    } stage_ctrl_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Largest representable accumulator value of the given width.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input logic is_signed, input int width);
        logic [SAT_MAX_W-1:0] one;
        one = 1;
        return is_signed ? (one << (width - 1)) - one : (one << width) - one;
    endfunction

    // Smallest representable accumulator value of the given width.
    function automatic logic [SAT_MAX_W-1:0] sat_min(input logic is_signed, input int width);
        logic [SAT_MAX_W-1:0] one;
        one = 1;
        return is_signed ? ~((one << (width - 1)) - one) : '0;
    endfunction

endpackage

// File: rtl/mult_accum_mul.sv
// rtl/mult_accum_mul.sv - input register and signed/unsigned multiplier with product register
//
// Ports:
//   clock0, aclr0, ena      clock, async active-low clear, pipeline enable
//   in_ctrl, in_ch          control payload and channel of the incoming sample
//   dataa, datab            operands
//   signa, signb            per-operand two's complement flags
//   prod                    product extended to WIDTH_RESULT
//   prod_ctrl, prod_ch      payload and channel aligned with prod
module mult_accum_mul
    import mult_accum_pkg::*;
#(
    parameter int WIDTH_A      = 16,
    parameter int WIDTH_B      = 16,
    parameter int WIDTH_RESULT = 40,
    parameter int CH_W         = 2
) (
    input  logic                    clock0,
    input  logic                    aclr0,
    input  logic                    ena,
    input  stage_ctrl_t             in_ctrl,
    input  logic [CH_W-1:0]         in_ch,
    input  logic [WIDTH_A-1:0]      dataa,
    input  logic [WIDTH_B-1:0]      datab,
    input  logic                    signa,
    input  logic                    signb,
    output logic [WIDTH_RESULT-1:0] prod,
    output stage_ctrl_t             prod_ctrl,
    output logic [CH_W-1:0]         prod_ch
);

    localparam int PW = WIDTH_A + WIDTH_B;

    logic [WIDTH_A-1:0]      a_r;
    logic [WIDTH_B-1:0]      b_r;
    logic                    sa_r;
    logic                    sb_r;
    stage_ctrl_t             ctrl1;
    logic [CH_W-1:0]         ch1;

    logic signed [WIDTH_A:0] a_ext;
    logic signed [WIDTH_B:0] b_ext;
    logic [PW-1:0]           p_lo;
    logic [WIDTH_RESULT-1:0] prod_next;

    // Each operand gets one extra bit holding its own sign (or zero), so a single
    // signed multiply covers all four signa/signb combinations. The exact product
    // always fits in WIDTH_A+WIDTH_B bits, so only those low bits are computed.
    always_comb begin
        a_ext     = {sa_r & a_r[WIDTH_A-1], a_r};
        b_ext     = {sb_r & b_r[WIDTH_B-1], b_r};
        p_lo      = PW'(a_ext) * PW'(b_ext);
        prod_next = ctrl1.is_signed ? WIDTH_RESULT'($signed(p_lo)) : WIDTH_RESULT'(p_lo);
    end

    always_ff @(posedge clock0 or negedge aclr0) begin
        if (!aclr0) begin
            a_r       <= '0;
            b_r       <= '0;
            sa_r      <= 1'b0;
            sb_r      <= 1'b0;
            ctrl1     <= '0;
            ch1       <= '0;
            prod      <= '0;
            prod_ctrl <= '0;
            prod_ch   <= '0;
        end else if (ena) begin
            a_r       <= dataa;
            b_r       <= datab;
            sa_r      <= signa;
            sb_r      <= signb;
            ctrl1     <= in_ctrl;
            ch1       <= in_ch;
            prod      <= prod_next;
            prod_ctrl <= ctrl1;
            prod_ch   <= ch1;
        end
    end

endmodule

// File: rtl/mult_accum_mc.sv
// rtl/mult_accum_mc.sv - multi-channel 3-stage multiply-accumulate (option: MULT_ACCUM_SATURATION_EN)
//
// Ports:
//   clock0, aclr0, ena          clock, async active-low clear, pipeline enable
//   in_valid, ch                sample qualifier and target channel
//   dataa, datab, signa, signb  operands and their signedness
//   addnsub, accum_sload        add/subtract product, load instead of accumulate
//   result, out_valid, out_ch   updated accumulator, qualifier and its channel
//   overflow                    sticky overflow flag of out_ch
//   accum_is_saturated          (MULT_ACCUM_SATURATION_EN only) update was clamped
module mult_accum_mc
    import mult_accum_pkg::*;
#(
    parameter int WIDTH_A      = 16,
    parameter int WIDTH_B      = 16,
    parameter int WIDTH_RESULT = 40,
    parameter int NUM_CH       = 4,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                    clock0,
    input  logic                    aclr0,
    input  logic                    ena,
    input  logic                    in_valid,
    input  logic [WIDTH_A-1:0]      dataa,
    input  logic [WIDTH_B-1:0]      datab,
    input  logic [CH_W-1:0]         ch,
    input  logic                    signa,
    input  logic                    signb,
    input  logic                    addnsub,
    input  logic                    accum_sload,
`ifdef MULT_ACCUM_SATURATION_EN
    output logic                    accum_is_saturated,
`endif
    output logic [WIDTH_RESULT-1:0] result,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic                    overflow
);

    localparam int W = WIDTH_RESULT;

`ifdef MULT_ACCUM_SATURATION_EN
    localparam logic [W-1:0] SMAX = W'(sat_max(1'b1, W));
    localparam logic [W-1:0] SMIN = W'(sat_min(1'b1, W));
    localparam logic [W-1:0] UMAX = W'(sat_max(1'b0, W));
    localparam logic [W-1:0] UMIN = W'(sat_min(1'b0, W));
`endif

    stage_ctrl_t       in_ctrl;
    logic [W-1:0]      prod;
    stage_ctrl_t       prod_ctrl;
    logic [CH_W-1:0]   prod_ch;

    logic [W-1:0]      acc [NUM_CH];
    logic [NUM_CH-1:0] ovf_flags;

    logic [W-1:0]      base;
    logic [W:0]        ext_base;
    logic [W:0]        ext_p;
    logic [W:0]        sum;
    logic              ovf_now;
    logic              ovf_next;
    logic [W-1:0]      new_val;

    // Out-of-range channels enter the pipeline as bubbles so they never touch state.
    always_comb begin
        in_ctrl           = '0;
        in_ctrl.valid     = in_valid & ({1'b0, ch} < (CH_W + 1)'(NUM_CH));
        in_ctrl.is_signed = signa | signb;
        in_ctrl.addnsub   = addnsub;
        in_ctrl.sload     = accum_sload;
    end

    mult_accum_mul #(
        .WIDTH_A      (WIDTH_A),
        .WIDTH_B      (WIDTH_B),
        .WIDTH_RESULT (WIDTH_RESULT),
        .CH_W         (CH_W)
    ) u_mul (
        .clock0    (clock0),
        .aclr0     (aclr0),
        .ena       (ena),
        .in_ctrl   (in_ctrl),
        .in_ch     (ch),
        .dataa     (dataa),
        .datab     (datab),
        .signa     (signa),
        .signb     (signb),
        .prod      (prod),
        .prod_ctrl (prod_ctrl),
        .prod_ch   (prod_ch)
    );

    // Stage 3 reads and writes the accumulator in the same cycle, so back-to-back
    // samples on one channel chain naturally. The add is done one bit wider: in
    // signed mode the top two bits disagree on overflow; in unsigned mode the top
    // bit is the carry (add) or borrow (subtract).
    always_comb begin
        base     = prod_ctrl.sload ? '0 : acc[prod_ch];
        ext_base = prod_ctrl.is_signed ? {base[W-1], base} : {1'b0, base};
        ext_p    = prod_ctrl.is_signed ? {prod[W-1], prod} : {1'b0, prod};
        sum      = prod_ctrl.addnsub ? ext_base + ext_p : ext_base - ext_p;
        ovf_now  = prod_ctrl.is_signed ? (sum[W] ^ sum[W-1]) : sum[W];
        ovf_next = ovf_now | (~prod_ctrl.sload & ovf_flags[prod_ch]);
        new_val  = sum[W-1:0];
`ifdef MULT_ACCUM_SATURATION_EN
        // The wide sum carries the true sign of a signed result; unsigned overflow
        // direction follows the operation.
        if (ovf_now) begin
            if (prod_ctrl.is_signed) begin
                new_val = sum[W] ? SMIN : SMAX;
            end else begin
                new_val = prod_ctrl.addnsub ? UMAX : UMIN;
            end
        end
`endif
    end

    always_ff @(posedge clock0 or negedge aclr0) begin
        if (!aclr0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            ovf_flags <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            overflow  <= 1'b0;
`ifdef MULT_ACCUM_SATURATION_EN
            accum_is_saturated <= 1'b0;
`endif
        end else if (ena) begin
            out_valid <= prod_ctrl.valid;
`ifdef MULT_ACCUM_SATURATION_EN
            accum_is_saturated <= prod_ctrl.valid & ovf_now;
`endif
            if (prod_ctrl.valid) begin
                acc[prod_ch]       <= new_val;
                ovf_flags[prod_ch] <= ovf_next;
                result             <= new_val;
                out_ch             <= prod_ch;
                overflow           <= ovf_next;
            end
        end
    end

endmodule
